ram_arbiter: RTL and testbench

- Two-requester arbiter sharing the single-port data RAM (32-bit words, word address a[31:2], synchronous write, combinational read with read enable).
- Requester 0 is the CPU load/store port; requester 1 is the DMA/program loader.
- Grants one access per cycle with round-robin fairness and optional bounded burst lock.
- Drives the RAM port and returns registered read data to the winner.

---
 rtl/ram_arbiter_if.sv | 18 +
 rtl/ram_arbiter.sv | 111 +++++++++++
 tb/tb_ram_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Requester-side port of the data-RAM arbiter: request/write/lock/address/data
// in, grant and registered read data back.
interface ram_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic          lock;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (output req, we, lock, addr, wdata, input  gnt, rvalid, rdata);
  modport slave  (input  req, we, lock, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester arbiter for the single-port data RAM: round-robin with a bounded
// burst lock, same-cycle combinational grant, one-cycle registered read return.
module ram_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int BURST_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  ram_arbiter_if.slave  rq0,
  ram_arbiter_if.slave  rq1,
  output logic [AW-1:0] ram_a,
  output logic          ram_we,
  output logic          ram_re,
  output logic [DW-1:0] ram_wd,
  input  logic [DW-1:0] ram_rd
);
  localparam int            CW      = $clog2(BURST_MAX) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BURST_MAX - 1);

  logic          owner_q, owner_d;
  logic          owner_vld_q, owner_vld_d;
  logic          last_q, last_d;
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;
  logic          rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic [1:0] req;
  logic       hold, grant, winner, we_w, lock_w;

  assign req = {rq1.req, rq0.req};

  // The lock holder keeps the RAM unless its burst is used up while the other side waits.
  assign hold = owner_vld_q && req[owner_q] && ((burst_cnt_q < CNT_MAX) || !req[~owner_q]);

  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default first, so no latch is inferred.
    grant  = 1'b0;
    winner = 1'b0;
    if (!reset) begin
      if (hold) begin
        grant  = 1'b1;
        winner = owner_q;
      end else if (&req) begin
        grant  = 1'b1;
        winner = ~last_q;
      end else if (|req) begin
        grant  = 1'b1;
        winner = req[1];
      end
    end
  end

  // winner stays 0 without a grant, so the idle RAM port shows requester 0's address/data.
  assign we_w    = winner ? rq1.we    : rq0.we;
  assign lock_w  = winner ? rq1.lock  : rq0.lock;
  assign ram_a   = winner ? rq1.addr  : rq0.addr;
  assign ram_wd  = winner ? rq1.wdata : rq0.wdata;
  assign ram_we  = grant &  we_w;
  assign ram_re  = grant & ~we_w;
  assign rq0.gnt = grant & ~winner;
  assign rq1.gnt = grant &  winner;

  always_comb begin
    last_d      = last_q;
    owner_d     = owner_q;
    owner_vld_d = 1'b0;
    burst_cnt_d = '0;
    rvalid0_d   = grant & ~we_w & ~winner;
    rvalid1_d   = grant & ~we_w &  winner;
    rdata0_d    = rvalid0_d ? ram_rd : rdata0_q;
    rdata1_d    = rvalid1_d ? ram_rd : rdata1_q;
    if (grant) begin
      last_d      = winner;
      owner_d     = winner;
      owner_vld_d = lock_w;
      // Saturates only when the owner is allowed to continue because the other side is idle.
      if (winner == last_q && owner_vld_q)
        burst_cnt_d = (burst_cnt_q == CNT_MAX) ? CNT_MAX : burst_cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q     <= 1'b0;
      owner_vld_q <= 1'b0;
      last_q      <= 1'b1;
      burst_cnt_q <= '0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      // NOTE: read-data registers are reset (unlike a RAM array) so a cancelled read returns zero.
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      owner_q     <= owner_d;
      owner_vld_q <= owner_vld_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  assign rq0.rvalid = rvalid0_q;
  assign rq1.rvalid = rvalid1_q;
  assign rq0.rdata  = rdata0_q;
  assign rq1.rdata  = rdata1_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus randomized traffic
// compared against a streak-counting arbitration model and a shadow RAM.
module tb_ram_arbiter;
  localparam int BURST_MAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ram_a, ram_wd, ram_rd;
  logic        ram_we, ram_re;
  logic [31:0] mem [64];

  ram_arbiter_if #(.AW(32), .DW(32)) i0 ();
  ram_arbiter_if #(.AW(32), .DW(32)) i1 ();

  ram_arbiter #(.AW(32), .DW(32), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .reset(reset), .rq0(i0), .rq1(i1),
    .ram_a(ram_a), .ram_we(ram_we), .ram_re(ram_re), .ram_wd(ram_wd), .ram_rd(ram_rd)
  );

  always #5 clk = ~clk;

  // Environment RAM: 64 words, index wraps on address bits [7:2].
  assign ram_rd = mem[ram_a[7:2]];
  always @(posedge clk) if (ram_we) mem[ram_a[7:2]] <= ram_wd;

  typedef struct packed {
    logic        gnt0, gnt1, we, re, rv0, rv1;
    logic [31:0] a, wd, rd0, rd1;
  } snap_t;

  snap_t obs, exp;
  int    checks = 0;
  int    errors = 0;

  // Reference model: who holds a lock, how many consecutive locked grants it has had.
  int          m_last, m_holder, m_streak;
  logic        m_rv [2];
  logic [31:0] m_rd [2];
  logic [31:0] ref_mem [64];

  function automatic logic rq(int k);
    return (k == 1) ? i1.req : i0.req;
  endfunction

  task automatic model_reset();
    m_last = 1; m_holder = -1; m_streak = 0;
    m_rv[0] = 1'b0; m_rv[1] = 1'b0; m_rd[0] = '0; m_rd[1] = '0;
  endtask

  // One clock: sample DUT outputs into obs, model prediction into exp, advance model.
  task automatic step();
    int          w;
    logic        we_w, lk_w;
    logic [31:0] a_w, wd_w;
    @(negedge clk); #1;
    if (reset) model_reset();
    w = -1;
    if (!reset) begin
      if (m_holder >= 0 && rq(m_holder) && (m_streak < BURST_MAX || !rq(1 - m_holder))) w = m_holder;
      else if (i0.req && i1.req) w = 1 - m_last;
      else if (i0.req) w = 0;
      else if (i1.req) w = 1;
    end
    we_w = (w == 1) ? i1.we : i0.we;
    lk_w = (w == 1) ? i1.lock : i0.lock;
    a_w  = (w == 1) ? i1.addr : i0.addr;
    wd_w = (w == 1) ? i1.wdata : i0.wdata;
    exp.gnt0 = (w == 0); exp.gnt1 = (w == 1);
    exp.we = (w >= 0) && we_w; exp.re = (w >= 0) && !we_w;
    exp.a = a_w; exp.wd = wd_w;
    exp.rv0 = m_rv[0]; exp.rv1 = m_rv[1]; exp.rd0 = m_rd[0]; exp.rd1 = m_rd[1];
    obs.gnt0 = i0.gnt; obs.gnt1 = i1.gnt; obs.we = ram_we; obs.re = ram_re;
    obs.a = ram_a; obs.wd = ram_wd;
    obs.rv0 = i0.rvalid; obs.rv1 = i1.rvalid; obs.rd0 = i0.rdata; obs.rd1 = i1.rdata;
    @(posedge clk);
    if (reset) model_reset();
    else begin
      m_rv[0] = 1'b0; m_rv[1] = 1'b0;
      if (w >= 0) begin
        if (we_w) ref_mem[a_w[7:2]] = wd_w;
        else begin m_rv[w] = 1'b1; m_rd[w] = ref_mem[a_w[7:2]]; end
        m_streak = (m_holder == w) ? m_streak + 1 : 1;
        m_holder = lk_w ? w : -1;
        m_last   = w;
      end else m_holder = -1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    i0.req = 0; i0.we = 0; i0.lock = 0; i0.addr = '0; i0.wdata = '0;
    i1.req = 0; i1.we = 0; i1.lock = 0; i1.addr = '0; i1.wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    i0.req = 1; i1.req = 1; i0.we = 1; i1.we = 0;
    step();
    checks++; if ({obs.gnt0, obs.gnt1} !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b want 00", {obs.gnt0, obs.gnt1}); end
    checks++; if ({obs.we, obs.re} !== 2'b00) begin errors++; $display("FAIL reset_ram_en: got %b want 00", {obs.we, obs.re}); end
    checks++; if ({obs.rv0, obs.rv1, obs.rd0, obs.rd1} !== '0) begin errors++; $display("FAIL reset_rdata: got rv=%b%b rd0=%h rd1=%h want zeros", obs.rv0, obs.rv1, obs.rd0, obs.rd1); end
    do_reset();
  endtask

  task automatic test_write_read();
    do_reset();
    i0.req = 1; i0.we = 1; i0.addr = 32'h10; i0.wdata = 32'hDEADBEEF;
    step();
    checks++; if ({obs.gnt0, obs.gnt1, obs.we, obs.re} !== 4'b1010) begin errors++; $display("FAIL wr_grant: got gnt0/gnt1/we/re=%b want 1010", {obs.gnt0, obs.gnt1, obs.we, obs.re}); end
    checks++; if (obs.a !== 32'h10 || obs.wd !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_bus: got a=%h wd=%h want 10 deadbeef", obs.a, obs.wd); end
    i0.we = 0;
    step();
    checks++; if ({obs.gnt0, obs.we, obs.re, obs.rv0} !== 4'b1010) begin errors++; $display("FAIL rd_grant: got gnt0/we/re/rv0=%b want 1010", {obs.gnt0, obs.we, obs.re, obs.rv0}); end
    i0.req = 0;
    step();
    checks++; if (obs.rv0 !== 1'b1 || obs.rd0 !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_return: got rv0=%b rd0=%h want 1 deadbeef", obs.rv0, obs.rd0); end
    step();
    checks++; if (obs.rv0 !== 1'b0 || obs.rd0 !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_hold: got rv0=%b rd0=%h want 0 deadbeef", obs.rv0, obs.rd0); end
  endtask

  task automatic test_alternate();
    do_reset();
    i0.req = 1; i1.req = 1; i0.we = 1; i1.we = 1;
    for (int k = 0; k < 6; k++) begin
      i0.wdata = $urandom; i1.wdata = $urandom;
      step();
      checks++; if ({obs.gnt0, obs.gnt1} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL alternate[%0d]: got gnt0/gnt1=%b%b", k, obs.gnt0, obs.gnt1); end
    end
  endtask

  task automatic test_burst_lock();
    int seq [6] = '{0, 0, 0, 0, 1, 0};
    do_reset();
    i0.req = 1; i0.lock = 1; i1.req = 1; i1.lock = 0;
    for (int k = 0; k < 6; k++) begin
      i0.addr = $urandom; i1.addr = $urandom;
      step();
      checks++; if ({obs.gnt0, obs.gnt1} !== ((seq[k] == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL burst[%0d]: got gnt0/gnt1=%b%b want requester %0d", k, obs.gnt0, obs.gnt1, seq[k]); end
    end
  endtask

  task automatic test_saturate();
    int   got;
    logic bad;
    do_reset();
    i0.req = 1; i0.lock = 1; i1.req = 0;
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (obs.gnt0 !== 1'b1) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL sat_hold: got a missed gnt0 want gnt0 on all 10 cycles"); end
    i1.req = 1;
    got = -1;
    for (int k = 0; k < BURST_MAX && got < 0; k++) begin
      step();
      if (obs.gnt1 === 1'b1) got = k;
    end
    checks++; if (got < 0) begin errors++; $display("FAIL sat_yield: got no gnt1 want gnt1 within %0d cycles", BURST_MAX); end
  endtask

  task automatic test_owner_drop();
    do_reset();
    i0.req = 1; i0.lock = 1; i1.req = 1;
    step(); step();
    i0.req = 0;
    step();
    checks++; if ({obs.gnt0, obs.gnt1} !== 2'b01) begin errors++; $display("FAIL drop: got gnt0/gnt1=%b%b want 01", obs.gnt0, obs.gnt1); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    i1.req = 1; i1.we = 1; i1.addr = 32'h24; i1.wdata = 32'hA5A5_0F0F;
    step();
    i1.we = 0;
    step();
    step();
    checks++; if (obs.rv1 !== 1'b1 || obs.rd1 !== 32'hA5A5_0F0F) begin errors++; $display("FAIL pre_reset_rd: got rv1=%b rd1=%h want 1 a5a50f0f", obs.rv1, obs.rd1); end
    reset = 1'b1;
    step();
    checks++; if ({obs.gnt1, obs.re, obs.rv1} !== 3'b000 || obs.rd1 !== '0) begin errors++; $display("FAIL mid_reset: got gnt1/re/rv1=%b rd1=%h want 000 0", {obs.gnt1, obs.re, obs.rv1}, obs.rd1); end
    reset = 1'b0;
    i0.req = 1; i0.we = 0;
    step();
    checks++; if ({obs.gnt0, obs.gnt1, obs.rv1} !== 3'b100) begin errors++; $display("FAIL post_reset_tie: got gnt0/gnt1/rv1=%b want 100", {obs.gnt0, obs.gnt1, obs.rv1}); end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      i0.req = ($urandom_range(0, 3) != 0); i0.we = 1'($urandom_range(0, 1)); i0.lock = ($urandom_range(0, 2) != 0);
      i1.req = ($urandom_range(0, 3) != 0); i1.we = 1'($urandom_range(0, 1)); i1.lock = ($urandom_range(0, 2) != 0);
      i0.addr = $urandom; i0.wdata = $urandom; i1.addr = $urandom; i1.wdata = $urandom;
      reset = ($urandom_range(0, 79) == 0);
      step();
      checks++; if (obs.gnt0 !== exp.gnt0) begin errors++; $display("FAIL rnd_gnt0[%0d]: got %b want %b", k, obs.gnt0, exp.gnt0); end
      checks++; if (obs.gnt1 !== exp.gnt1) begin errors++; $display("FAIL rnd_gnt1[%0d]: got %b want %b", k, obs.gnt1, exp.gnt1); end
      checks++; if ({obs.we, obs.re} !== {exp.we, exp.re}) begin errors++; $display("FAIL rnd_we_re[%0d]: got %b%b want %b%b", k, obs.we, obs.re, exp.we, exp.re); end
      checks++; if (obs.a !== exp.a || obs.wd !== exp.wd) begin errors++; $display("FAIL rnd_bus[%0d]: got a=%h wd=%h want a=%h wd=%h", k, obs.a, obs.wd, exp.a, exp.wd); end
      checks++; if ({obs.rv0, obs.rv1} !== {exp.rv0, exp.rv1}) begin errors++; $display("FAIL rnd_rvalid[%0d]: got %b%b want %b%b", k, obs.rv0, obs.rv1, exp.rv0, exp.rv1); end
      checks++; if (obs.rd0 !== exp.rd0 || obs.rd1 !== exp.rd1) begin errors++; $display("FAIL rnd_rdata[%0d]: got %h %h want %h %h", k, obs.rd0, obs.rd1, exp.rd0, exp.rd1); end
    end
    reset = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 64; k++) begin mem[k] = '0; ref_mem[k] = '0; end
    idle_inputs();
    model_reset();
    reset = 1'b1;
    test_reset();
    test_write_read();
    test_alternate();
    test_burst_lock();
    test_saturate();
    test_owner_drop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
